// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: FSM encoding,
// forwarding-mux select codes and the default memory timeout.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// EX operand forwarding select for one source register; the younger EX/MEM
// result wins over MEM/WB, and register 0 is never forwarded.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regw,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regw,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regw && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_regw && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage MIPS sequencing controller: BOOT/RUN/MEM_WAIT FSM, freeze on data
// memory wait, branch/load-use/jump handling, forwarding. Optional perf
// counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW          = 5,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_jump,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_regw,
  input  logic          ex_memtoreg,
  input  logic          ex_br_taken,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regw,
  input  logic          mem_req,
  input  logic          mem_ready,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regw,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          exmem_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          memwb_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mem_err,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       active, freeze, load_use;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  fwd_sel #(.AW(AW)) u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_regw(mem_regw),
    .wb_rd(wb_rd), .wb_regw(wb_regw), .sel(fwd_a_sel)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_regw(mem_regw),
    .wb_rd(wb_rd), .wb_regw(wb_regw), .sel(fwd_b_sel)
  );

  assign load_use = ex_memtoreg && ex_regw && (ex_rd != '0) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

  // The cycle that sees mem_ready or the timeout already runs unfrozen.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    active     = 1'b0;
    freeze     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        active = 1'b1;
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        active = 1'b1;
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!active) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      memwb_bubble = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign fwd_a   = active ? fwd_a_sel : FWD_RF;
  assign fwd_b   = active ? fwd_b_sel : FWD_RF;
  assign mem_err = mem_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && !pc_en) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((state_q == ST_RUN) && ifid_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage MIPS core.
- Sits beside the main decoder and drives the stage-register enables/flushes and the EX forwarding muxes.
- Handles load-use stalls, taken branches resolved in EX, jumps decoded in ID, and a multi-cycle data-memory handshake with timeout.
- Holds the start-up (BOOT) and memory-wait state machine.

Parameters:
- AW, 5, register-address width.
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abort; legal range 2..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  AW  ID-stage source registers
- id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt
- id_jump  in  1  J/JAL decoded in ID
- ex_rs, ex_rt  in  AW  EX-stage source registers
- ex_rd  in  AW  EX destination
- ex_regw, ex_memtoreg  in  1  EX writes reg / is a load
- ex_br_taken  in  1  BEQ/BNE resolved taken in EX
- mem_rd  in  AW  MEM destination
- mem_regw  in  1  MEM writes reg
- mem_req  in  1  load/store present in MEM (level)
- mem_ready  in  1  data memory done (pulse)
- wb_rd  in  AW  WB destination
- wb_regw  in  1  WB writes reg
- pc_en, ifid_en, idex_en, exmem_en  out  1  stage-register enables
- ifid_flush, idex_flush, memwb_bubble  out  1  insert a NOP into that register
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt  out  32  performance counters

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- State machine states: BOOT, RUN, MEM_WAIT. Reset forces state=BOOT, wait counter=0, mem_err=0, counters=0.
- BOOT (exactly one cycle after rst_n release):
  - All enables are 0; ifid_flush=idex_flush=memwb_bubble=1; fwd=00.
  - Next state is RUN.
- RUN with mem_req=1 and mem_ready=0: assert freeze this cycle; next state is MEM_WAIT.
- RUN with mem_req=1 and mem_ready=1: no stall.
- MEM_WAIT:
  - Freeze every cycle; increment the wait counter.
  - mem_ready=1: release freeze in that same cycle; next state is RUN; counter cleared.
  - Counter reaches MEM_TIMEOUT-1 without ready: set mem_err, release freeze, return to RUN. mem_err is cleared only by reset.
- Freeze:
  - pc_en=ifid_en=idex_en=exmem_en=0 and memwb_bubble=1.
  - All flushes are suppressed; pending branch, jump and load-use conditions stay asserted by the frozen stages and are applied on release.
- Priority outside freeze is branch > load-use > jump.
  - ex_br_taken: ifid_flush=1, idex_flush=1, all enables 1 (overrides a simultaneous load-use or jump, which are wrong-path).
  - Load-use: ex_memtoreg & ex_regw & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)) gives pc_en=ifid_en=0 and idex_flush=1 for one cycle.
  - id_jump (no branch, no load-use): ifid_flush=1.
- Forwarding (fwd_a shown for ex_rs; fwd_b identical for ex_rt):
  - 10 if mem_regw & mem_rd!=0 & mem_rd==ex_rs.
  - Else 01 if wb_regw & wb_rd!=0 & wb_rd==ex_rs.
  - Else 00. EX/MEM wins when both stages match.
- Register 0 never triggers a stall or a forward.
- All control outputs are combinational from state + inputs; only state, wait counter, mem_err and perf counters are registered.
- Reset mid-MEM_WAIT returns to BOOT immediately and clears everything.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_en=0 in RUN/MEM_WAIT.
  - flush_cnt increments on every cycle with ifid_flush=1 in RUN.
  - Both wrap at 2^32.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding (BOOT/RUN/MEM_WAIT);
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - default MEM_TIMEOUT.
- One combinational sub-module fwd_sel, instantiated twice (operand A/B).

Test Plan:
- Reset release → BOOT cycle with all enables 0 and all flushes 1; RUN next cycle with all enables 1 and no flushes.
- Load-use: EX lw ex_rd=8, ID add id_rs=8 → one cycle pc_en=ifid_en=0, idex_flush=1; same case with ex_rd=0 → no stall.
- Forwarding: mem_rd=wb_rd=ex_rs=5, both regw=1 → fwd_a=10; clear mem_regw → fwd_a=01.
- Memory wait: mem_req=1, mem_ready arrives 3 cycles later → freeze 3 cycles then release; stall_cnt +3 with macro defined.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserted → mem_err=1 after 4 frozen cycles, pipeline released, mem_err held.
- ex_br_taken + load-use + id_jump together → ifid_flush=idex_flush=1, pc_en=1; the same triple during freeze → no flush until release.
